sa_mem: RTL and testbench
=========================

SA_MEM -- requirements
Module: sa_mem

Interface
REQ-001 Parameter N, default 5, meaning array dimension (N x N processing elements).
REQ-002 Parameter DW, default 32, meaning data, weight and result word width.
REQ-003 Parameter AW, default 8, meaning result-memory address width (2^AW words).
REQ-004 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 Port init, input, 1, meaning start request, level-sensitive.
REQ-007 Port com, output, 1, meaning operation complete.
REQ-008 Port base_address, input, AW, meaning first result-memory address written.
REQ-009 Ports in0..in4, input, DW each, meaning row elements A[k][0..4] of the input matrix.
REQ-010 The block SHALL contain a weight memory of N*N x DW words, W[i][j] at address i*N+j.
REQ-011 The weight memory SHALL have no port write path and SHALL be preloaded by the bench through hierarchy.
REQ-012 The block SHALL contain a result memory of 2^AW x DW words, readable by the bench through hierarchy.

Function
REQ-013 The controller SHALL use five states with fixed lengths: IDLE; LOAD 5 cycles; FEED 5 cycles; DRAIN 8 cycles; WRITE 25 cycles.
REQ-014 IDLE -> LOAD SHALL occur on a rising clk edge with init=1; LOAD SHALL transfer one weight row (N words) per cycle into the PE weight registers.
REQ-015 LOAD SHALL be followed by FEED; in FEED cycle k (k=0..4), in0..in4 SHALL be sampled as A[k][0..4].
REQ-016 Samples SHALL enter the array with skew: column i delayed i cycles, partial sums flow down columns.
REQ-017 The array SHALL compute C[k][j] = sum over i=0..4 of A[k][i]*W[i][j].
REQ-018 Arithmetic SHALL be unsigned; each product SHALL be truncated to DW bits and each accumulation taken modulo 2^DW.
REQ-019 DRAIN SHALL flush the skew, leaving all 25 results in result registers.
REQ-020 WRITE SHALL store one result per cycle in row-major order: C[k][j] at address (base_address + 5k + j) mod 2^AW.
REQ-021 base_address SHALL be sampled on the IDLE->LOAD edge; later changes SHALL have no effect on the running operation.
REQ-022 After WRITE, the controller SHALL enter DONE with com=1.
REQ-023 com SHALL rise exactly 43 clock edges after the IDLE->LOAD edge.
REQ-024 com SHALL be 1 only in DONE; DONE -> IDLE SHALL occur on the first edge with init=0, so a held init never retriggers.
REQ-025 init changes during LOAD/FEED/DRAIN/WRITE SHALL be ignored.
REQ-026 in0..in4 SHALL be don't-care outside FEED.
REQ-027 Result-memory words not addressed by the current WRITE SHALL be unchanged.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, com=0, and clear PE accumulators, skew registers and result registers.
REQ-029 Reset SHALL not clear the weight or result memories.
REQ-030 rst asserted mid-operation SHALL abort it; writes already performed SHALL remain and no further writes SHALL occur.
REQ-031 After rst deasserts, a new operation SHALL start only via REQ-014.

Verification
REQ-032 Identity weights W=I, base 0, in0..in4 held at 3,7,11,13,17 through FEED, init held 1 -> MEM[5k+j] = that row for every k; com rises 43 edges after start.
REQ-033 All weights 1, inputs 1..5 constant -> all 25 results = 15.
REQ-034 base_address=250 -> writes wrap: addresses 250..255 then 0..18; addresses 19..249 unchanged.
REQ-035 Weights and inputs 0xFFFFFFFF -> each result = 5 mod 2^32 = 5.
REQ-036 rst pulsed in FEED cycle 2 -> com=0 immediately, no memory writes; after re-init, a fresh run produces correct results.
REQ-037 init held high after com -> com stays 1 with no rerun; init low -> IDLE; init high -> a new run starts.

Source files
------------

// File: rtl/sa_mem.sv
// sa_mem: N x N weight-stationary systolic multiplier. Weights come from an
// internal memory; the N*N products are written row-major into a result memory.
module sa_mem #(
  parameter int N  = 5,
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  output logic          com,
  input  logic [AW-1:0] base_address,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic [DW-1:0] in4,
  output logic [2:0]    dbg_state,
  output logic [DW-1:0] dbg_rdata
);

  // Handshake: init is a level request sampled only in IDLE; com is high only
  // in DONE and stays high until init is seen low, so a held init never reruns.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int         RW         = $clog2(N * N);
  localparam logic [5:0] LOAD_LAST  = 6'(N - 1);
  localparam logic [5:0] FEED_LAST  = 6'(N - 1);
  localparam logic [5:0] DRAIN_LAST = 6'(2 * N - 3);
  localparam logic [5:0] WRITE_LAST = 6'(N * N - 1);

  state_t        state;
  logic [5:0]    cnt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] wr_addr;
  logic          feeding;
  logic          sweeping;
  int            cap_t;

  // No write port: contents are placed here from outside before a run.
  logic [DW-1:0] w_mem   [N*N] = '{default: '0};
  logic [DW-1:0] res_mem [2**AW];

  logic [DW-1:0] w_reg   [N][N];
  logic [DW-1:0] skew    [N][N-1];
  logic [DW-1:0] a_reg   [N][N-1];
  logic [DW-1:0] p_reg   [N-1][N];
  logic [DW-1:0] res_reg [N*N];
  logic [DW-1:0] in_v    [N];
  logic [DW-1:0] row_in  [N];
  logic [DW-1:0] a_in    [N][N];
  logic [DW-1:0] psum    [N][N];

  assign in_v[0] = in0;
  assign in_v[1] = in1;
  assign in_v[2] = in2;
  assign in_v[3] = in3;
  assign in_v[4] = in4;

  assign feeding   = (state == FEED);
  assign sweeping  = (state == FEED) || (state == DRAIN);
  assign cap_t     = (state == DRAIN) ? int'(cnt) + N : int'(cnt);
  assign wr_addr   = base_q + AW'(cnt);
  assign dbg_state = state;
  assign dbg_rdata = res_mem[wr_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      com    <= 1'b0;
      base_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            state  <= LOAD;
            cnt    <= '0;
            base_q <= base_address;
          end
        end
        LOAD: begin
          if (cnt == LOAD_LAST) begin
            state <= FEED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FEED: begin
          if (cnt == FEED_LAST) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= WRITE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        WRITE: begin
          if (cnt == WRITE_LAST) begin
            state <= DONE;
            cnt   <= '0;
            com   <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (!init) begin
            state <= IDLE;
            com   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          com   <= 1'b0;
        end
      endcase
    end
  end

  // Row i of the array sees A[k][i] in sweep cycle k+i; row 0 takes the port directly.
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i == 0) begin : g_direct
      assign row_in[i] = feeding ? in_v[i] : '0;
    end else begin : g_skewed
      assign row_in[i] = skew[i][i-1];
    end
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_edge
        assign a_in[i][j] = row_in[i];
      end else begin : g_pass
        assign a_in[i][j] = a_reg[i][j-1];
      end
      if (i == 0) begin : g_top
        assign psum[i][j] = a_in[i][j] * w_reg[i][j];
      end else begin : g_acc
        assign psum[i][j] = p_reg[i-1][j] + a_in[i][j] * w_reg[i][j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) w_reg[i][j] <= '0;
        for (int d = 0; d < N - 1; d++) begin
          skew[i][d]  <= '0;
          a_reg[i][d] <= '0;
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) p_reg[i][j] <= '0;
      end
      for (int r = 0; r < N * N; r++) res_reg[r] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        skew[i][0] <= feeding ? in_v[i] : '0;
        for (int d = 1; d < N - 1; d++) skew[i][d] <= skew[i][d-1];
        for (int j = 0; j < N - 1; j++) a_reg[i][j] <= a_in[i][j];
        for (int j = 0; j < N; j++) begin
          if (state == LOAD && int'(cnt) == i) w_reg[i][j] <= w_mem[i*N+j];
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) p_reg[i][j] <= psum[i][j];
      end
      // Column j finishes result row k at sweep cycle k + (N-1) + j.
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < N; j++) begin
          if (sweeping && cap_t == k + N - 1 + j) res_reg[k*N+j] <= psum[N-1][j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == WRITE) res_mem[wr_addr] <= res_reg[cnt[RW-1:0]];
  end

endmodule

// File: tb/tb_sa_mem.sv
// tb_sa_mem: directed runs of sa_mem; result memory checked by a scoreboard
// that drains its expected queue when com rises.
module tb_sa_mem;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 256;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DONE = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic          com;
  logic [AW-1:0] base_address = '0;
  logic [DW-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [2:0]    dbg_state;
  logic [DW-1:0] dbg_rdata;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  logic          com_d = 1'b0;
  logic [DW-1:0] shadow [MW];
  bit            known  [MW];
  logic [DW-1:0] w_mat  [N][N];
  logic [DW-1:0] a_mat  [N][N];
  logic [DW-1:0] c_mat  [N][N];
  int            total = 0;
  int            bad = 0;

  sa_mem #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .init(init), .com(com), .base_address(base_address),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .dbg_state(dbg_state), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_row(input int k);
    in0 = a_mat[k][0]; in1 = a_mat[k][1]; in2 = a_mat[k][2];
    in3 = a_mat[k][3]; in4 = a_mat[k][4];
  endtask

  task automatic drive_junk();
    in0 = $urandom(); in1 = $urandom(); in2 = $urandom();
    in3 = $urandom(); in4 = $urandom();
  endtask

  task automatic load_weights();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) dut.w_mem[i*N+j] = w_mat[i][j];
  endtask

  task automatic model_c();
    logic [DW-1:0] acc;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int i = 0; i < N; i++) acc = acc + DW'(a_mat[k][i] * w_mat[i][j]);
        c_mat[k][j] = acc;
      end
  endtask

  task automatic push_expect(input int base);
    int a;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        a = (base + N * k + j) % MW;
        shadow[a] = c_mat[k][j];
        known[a] = 1'b1;
      end
    for (int x = 0; x < MW; x++)
      if (known[x]) exp_q.push_back({AW'(x), shadow[x]});
  endtask

  task automatic check_known(input string tag);
    for (int x = 0; x < MW; x++)
      if (known[x]) check($sformatf("%s mem[%0d]", tag, x), dut.res_mem[x], shadow[x]);
  endtask

  // init_mode: 0 hold high, 1 drop after start, 2 random during the run
  task automatic run_op(input int base, input bit junk, input int init_mode,
                        input bit abort, input string tag);
    bit seen;
    @(negedge clk);
    base_address = AW'(base);
    init = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (com) begin
        seen = 1'b1;
        check({tag, " com_edge"}, DW'(n), 43);
      end else begin
        base_address = AW'($urandom());
        if (n >= 5 && n <= 9) drive_row(n - 5);
        else if (junk) drive_junk();
        else drive_row(0);
        case (init_mode)
          1: init = 1'b0;
          2: init = 1'($urandom_range(0, 1));
          default: init = 1'b1;
        endcase
        if (abort && n == 7) begin
          #2 rst = 1'b1;
          #1;
          check({tag, " rst_com"}, com, 0);
          check({tag, " rst_state"}, dbg_state, S_IDLE);
          return;
        end
      end
    end
    if (!seen) check({tag, " com_timeout"}, com, 1);
  endtask

  task automatic finish_op(input string tag);
    init = 1'b0;
    @(negedge clk);
    check({tag, " back_idle"}, dbg_state, S_IDLE);
  endtask

  always @(negedge clk) begin
    if (com && !com_d) begin
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check($sformatf("mem[%0d]", mon_e[AW+DW-1:DW]), dut.res_mem[mon_e[AW+DW-1:DW]],
              mon_e[DW-1:0]);
      end
    end
    com_d = com;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < MW; x++) known[x] = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_com", com, 0);
    check("reset_state", dbg_state, S_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_without_init", dbg_state, S_IDLE);

    // Identity weights: every result row equals the held input row.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) w_mat[i][j] = (i == j) ? 32'd1 : 32'd0;
    for (int k = 0; k < N; k++) begin
      a_mat[k][0] = 3; a_mat[k][1] = 7; a_mat[k][2] = 11; a_mat[k][3] = 13; a_mat[k][4] = 17;
      c_mat[k][0] = 3; c_mat[k][1] = 7; c_mat[k][2] = 11; c_mat[k][3] = 13; c_mat[k][4] = 17;
    end
    load_weights();
    push_expect(0);
    run_op(0, 1'b0, 0, 1'b0, "ident");
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      check("held_init_com", com, 1);
      check("held_init_state", dbg_state, S_DONE);
    end
    init = 1'b0;
    @(negedge clk);
    check("init_low_com", com, 0);
    check("init_low_state", dbg_state, S_IDLE);

    // All-ones weights, inputs 1..5: every result 15; init toggled mid-run.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_mat[i][j] = 32'd1;
        a_mat[i][j] = DW'(j + 1);
        c_mat[i][j] = 32'd15;
      end
    load_weights();
    push_expect(100);
    run_op(100, 1'b1, 2, 1'b0, "ones");
    finish_op("ones");

    // Distinct weights and rows, base near the top so addresses wrap.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_mat[i][j] = DW'(i * N + j + 1);
        a_mat[i][j] = DW'(i * N + j + 1);
      end
    model_c();
    load_weights();
    push_expect(250);
    run_op(250, 1'b1, 1, 1'b0, "wrap");
    finish_op("wrap");

    // All-ones words: each product truncates to 1, so each sum is 5.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_mat[i][j] = 32'hFFFF_FFFF;
        a_mat[i][j] = 32'hFFFF_FFFF;
        c_mat[i][j] = 32'd5;
      end
    load_weights();
    push_expect(30);
    run_op(30, 1'b1, 0, 1'b0, "max");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("done_rst_com", com, 0);
    check("done_rst_state", dbg_state, S_IDLE);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Abort in FEED cycle 2: nothing written, then a clean rerun.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        w_mat[i][j] = DW'(7 * i + j + 2);
        a_mat[i][j] = DW'(3 * i + 5 * j + 1);
      end
    load_weights();
    run_op(200, 1'b1, 0, 1'b1, "abort");
    init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_stays_idle", dbg_state, S_IDLE);
    check("abort_com", com, 0);
    check_known("abort");
    model_c();
    push_expect(200);
    run_op(200, 1'b1, 0, 1'b0, "rerun");
    finish_op("rerun");

    repeat (2) @(negedge clk);
    check("queue_drained", DW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
